// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_DEPTH = 32;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: storage mux, write-to-read bypass, zero-register masking and
// optional output register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_LAT = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr,
    input  logic [DW-1:0]     mem [DEPTH],
    input  logic [NWR-1:0]    wr_fire,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] rd_val;

    // wr_fire is already qualified, so a dropped write can never be forwarded.
    always_comb begin
        rd_val = mem[rd_addr];
        if (BYPASS != 0) begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_fire[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
                    rd_val = wr_data[p*DW +: DW];
                end
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_val = '0;
        end
    end

    generate
        if (BYPASS == 0) begin : g_no_bypass
            logic unused_wr;
            assign unused_wr = ^{wr_fire, wr_addr, wr_data};
        end

        if (READ_LAT != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_data <= '0;
                end else begin
                    rd_data <= rd_val;
                end
            end
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk ^ rst;
            assign rd_data    = rd_val;
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with bypass, optional registered read
// and a sequenced bulk-clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_LAT = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] mem [DEPTH];
    logic [NWR-1:0] wr_fire;
    logic          wr_open;

    assign wr_open = (state_q == CLR_IDLE);

    always_comb begin
        wr_fire = '0;
        for (int unsigned p = 0; p < NWR; p++) begin
            wr_fire[p] = wr_en[p] && wr_open &&
                         !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                clr_busy = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                clr_busy = 1'b1;
                clr_done = 1'b1;
                state_d  = CLR_IDLE;
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // Later ports are assigned last, so the highest-index port wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state_q == CLR_CLEAR) begin
            mem[cnt_q[AW-1:0]] <= '0;
        end else begin
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_fire[p]) begin
                    mem[wr_addr[p*AW +: AW]] <= wr_data[p*DW +: DW];
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            regfile_rd_port #(
                .DW       (DW),
                .DEPTH    (DEPTH),
                .NWR      (NWR),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS),
                .READ_LAT (READ_LAT)
            ) u_rd_port (
                .clk     (clk),
                .rst     (rst),
                .rd_addr (rd_addr[k*AW +: AW]),
                .mem     (mem),
                .wr_fire (wr_fire),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .rd_data (rd_data[k*DW +: DW])
            );
        end
    endgenerate

endmodule
